// File: rtl/fifo_sync.sv
// Single-clock FIFO over an inferred RAM; NORMAL mode has one-cycle read latency,
// FWFT mode presents the head word through an output register.
module fifo_sync #(
  parameter int    DSIZE             = 8,
  parameter int    ASIZE             = 4,
  parameter string MODE              = "NORMAL",
  parameter int    PROG_FULL_THRESH  = 2**ASIZE/2,
  parameter int    PROG_EMPTY_THRESH = 2**ASIZE/2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             prog_full,
  output logic             overflow,
  input  logic             rd_en,
  output logic [DSIZE-1:0] dout,
  output logic             empty,
  output logic             prog_empty,
  output logic             underflow,
  output logic [ASIZE:0]   count
);

  localparam int              DEPTH   = 2**ASIZE;
  localparam bit              FWFT    = (MODE == "FWFT");
  localparam logic [ASIZE:0]  DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0]  PF_C    = (ASIZE+1)'(PROG_FULL_THRESH);
  localparam logic [ASIZE:0]  PE_C    = (ASIZE+1)'(PROG_EMPTY_THRESH);

  if (!(MODE == "NORMAL" || MODE == "FWFT")) begin : g_bad_mode
    $error("fifo_sync: MODE must be \"NORMAL\" or \"FWFT\"");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH-1) begin : g_bad_pf
    $error("fifo_sync: PROG_FULL_THRESH out of range 1..DEPTH-1");
  end
  if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH-1) begin : g_bad_pe
    $error("fifo_sync: PROG_EMPTY_THRESH out of range 1..DEPTH-1");
  end

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ASIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic [ASIZE:0]   ram_cnt;
  logic [DSIZE-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             pfull_q, pfull_d;
  logic             pempty_q, pempty_d;
  logic             ovf_q, unf_q;
  logic             wr_acc, rd_acc, ram_rd;

  // valid_q is the "readable word present" flag: count!=0 in NORMAL,
  // output-register occupancy in FWFT.
  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && valid_q;
    ram_cnt  = count_q - {{ASIZE{1'b0}}, valid_q};
    ram_rd   = FWFT ? ((ram_cnt != '0) && (!valid_q || rd_acc)) : rd_acc;

    count_d  = count_q;
    if (wr_acc && !rd_acc)
      count_d = count_q + (ASIZE+1)'(1);
    else if (rd_acc && !wr_acc)
      count_d = count_q - (ASIZE+1)'(1);

    wr_ptr_d = wr_acc ? wr_ptr_q + ASIZE'(1) : wr_ptr_q;
    rd_ptr_d = ram_rd ? rd_ptr_q + ASIZE'(1) : rd_ptr_q;
    dout_d   = ram_rd ? mem_q[rd_ptr_q] : dout_q;
    valid_d  = FWFT ? (ram_rd || (valid_q && !rd_acc)) : (count_d != '0);

    full_d   = (count_d == DEPTH_C);
    pfull_d  = (count_d >= PF_C);
    pempty_d = (count_d <= PE_C);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      pfull_q  <= 1'b0;
      pempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      pfull_q  <= pfull_d;
      pempty_q <= pempty_d;
      ovf_q    <= wr_en && full_q;
      unf_q    <= rd_en && !valid_q;
    end
  end

  assign full       = full_q;
  assign prog_full  = pfull_q;
  assign overflow   = ovf_q;
  assign dout       = dout_q;
  assign empty      = !valid_q;
  assign prog_empty = pempty_q;
  assign underflow  = unf_q;
  assign count      = count_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Drives a NORMAL and an FWFT instance with shared stimulus and checks both
// against a queue-based reference model every cycle.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [7:0] din;

  logic       full_n, pf_n, ovf_n, empty_n, pe_n, unf_n;
  logic [7:0] dout_n;
  logic [4:0] count_n;
  logic       full_f, pf_f, ovf_f, empty_f, pe_f, unf_f;
  logic [7:0] dout_f;
  logic [4:0] count_f;

  int checks   = 0;
  int failures = 0;

  // index 0: NORMAL model, index 1: FWFT model
  logic [7:0] mq [2][$];
  bit         shown [2];
  logic [7:0] last  [2];
  bit         ovf_e [2];
  bit         unf_e [2];

  always #5 clk = ~clk;

  fifo_sync #(.DSIZE(8), .ASIZE(4), .MODE("NORMAL"),
              .PROG_FULL_THRESH(8), .PROG_EMPTY_THRESH(8)) u_norm (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full_n),
    .prog_full(pf_n), .overflow(ovf_n), .rd_en(rd_en), .dout(dout_n),
    .empty(empty_n), .prog_empty(pe_n), .underflow(unf_n), .count(count_n));

  fifo_sync #(.DSIZE(8), .ASIZE(4), .MODE("FWFT"),
              .PROG_FULL_THRESH(8), .PROG_EMPTY_THRESH(8)) u_fwft (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full_f),
    .prog_full(pf_f), .overflow(ovf_f), .rd_en(rd_en), .dout(dout_f),
    .empty(empty_f), .prog_empty(pe_f), .underflow(unf_f), .count(count_f));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the FIFO's contract: accepts judged on the state
  // before the edge, pops from the front, pushes at the back.
  task automatic model(input int m, input bit r, input bit w, input bit rd, input logic [7:0] d);
    bit rok, wok;
    if (r) begin
      mq[m].delete();
      shown[m] = 1'b0;
      last[m]  = 8'h00;
      ovf_e[m] = 1'b0;
      unf_e[m] = 1'b0;
      return;
    end
    rok = rd && ((m == 1) ? shown[m] : (mq[m].size() > 0));
    wok = w && (mq[m].size() < 16);
    ovf_e[m] = w && !wok;
    unf_e[m] = rd && !rok;
    if (rok) last[m] = mq[m].pop_front();
    // FWFT head is visible only if it was already stored before this edge
    shown[m] = (mq[m].size() > 0);
    if (wok) mq[m].push_back(d);
  endtask

  task automatic verify(input int m);
    string      pre;
    int         sz;
    logic       fl, pf, ov, em, pe, un;
    logic [7:0] dq;
    logic [4:0] cn;
    if (m == 0) begin
      pre = "norm"; fl = full_n; pf = pf_n; ov = ovf_n; em = empty_n;
      pe = pe_n; un = unf_n; dq = dout_n; cn = count_n;
    end else begin
      pre = "fwft"; fl = full_f; pf = pf_f; ov = ovf_f; em = empty_f;
      pe = pe_f; un = unf_f; dq = dout_f; cn = count_f;
    end
    sz = mq[m].size();
    chk({pre, ".count"},      32'(cn), 32'(sz));
    chk({pre, ".full"},       32'(fl), 32'(sz == 16));
    chk({pre, ".prog_full"},  32'(pf), 32'(sz >= 8));
    chk({pre, ".prog_empty"}, 32'(pe), 32'(sz <= 8));
    chk({pre, ".overflow"},   32'(ov), 32'(ovf_e[m]));
    chk({pre, ".underflow"},  32'(un), 32'(unf_e[m]));
    if (m == 0) begin
      chk({pre, ".empty"}, 32'(em), 32'(sz == 0));
      chk({pre, ".dout"},  32'(dq), 32'(last[0]));
    end else begin
      chk({pre, ".empty"}, 32'(em), 32'(!shown[1]));
      if (shown[1]) chk({pre, ".dout"}, 32'(dq), 32'(mq[1][0]));
    end
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    model(0, r, w, rd, d);
    model(1, r, w, rd, d);
    #1;
    verify(0);
    verify(1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("fwft.dout_rst", 32'(dout_f), 32'h0);

    // fill to full, then one rejected write
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hEE);
    step(0, 0, 0, 8'h00);

    // full: simultaneous read+write, write dropped
    step(0, 1, 1, 8'hEF);

    // drain, then extra reads
    repeat (18) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // empty: simultaneous read+write, read dropped; FWFT latency on 0xA5
    step(0, 1, 1, 8'hA5);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // hold count at 5 under continuous traffic; pointers wrap
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    step(0, 0, 0, 8'h00);
    repeat (40) step(0, 1, 1, 8'($urandom));
    repeat (8) step(0, 0, 1, 8'h00);

    // random traffic, write-heavy then read-heavy, rare resets
    repeat (250) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, 8'($urandom));
    repeat (250) step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) != 0, 8'($urandom));

    // reset mid-burst with count=10, then only new data comes back
    repeat (20) step(0, 0, 1, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(8'h40 + i));
    step(1, 1, 1, 8'h77);
    chk("fwft.dout_rst2", 32'(dout_f), 32'h0);
    step(0, 1, 0, 8'h3C);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("norm.dout_new", 32'(dout_n), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
